// File: rtl/huc6280_pkg.sv
// huc6280_pkg: shared register offsets, mask bit positions, default region
// bases and the address-region decode helper for the HuC6280 timer/IRQ block.
package huc6280_pkg;

    // Register offsets within each 1 KiB mirrored region
    localparam logic [1:0] TMR_CNT  = 2'd0;
    localparam logic [1:0] TMR_CTL  = 2'd1;
    localparam logic [1:0] IRQ_MASK = 2'd2;
    localparam logic [1:0] IRQ_STAT = 2'd3;

    // Bit positions shared by the mask register and the interrupt source vector
    localparam int unsigned IRQ2_BIT  = 0;
    localparam int unsigned IRQ1_BIT  = 1;
    localparam int unsigned TIMER_BIT = 2;

    // Default region bases
    localparam logic [15:0] TIMER_BASE_DEF = 16'h0C00;
    localparam logic [15:0] IRQC_BASE_DEF  = 16'h1400;

    typedef enum logic [1:0] {
        REG_NONE  = 2'd0,
        REG_TIMER = 2'd1,
        REG_IRQC  = 2'd2
    } region_e;

    // Only the top six address bits select a region; the rest mirror.
    function automatic region_e decode_region(input logic [15:0] a,
                                              input logic [15:0] tbase,
                                              input logic [15:0] ibase);
        region_e r;
        r = REG_NONE;
        if (a[15:10] == tbase[15:10]) begin
            r = REG_TIMER;
        end else if (a[15:10] == ibase[15:10]) begin
            r = REG_IRQC;
        end
        return r;
    endfunction

endpackage

// File: rtl/huc6280_timer.sv
// huc6280_timer: 7-bit interval timer with a PRESCALE-cycle prescaler.
// Owns reload, counter, run and prescaler; underflow_o is a one-cycle pulse
// asserted during the cycle whose closing edge reloads the counter.
// PRESCALE must be at least 2.
module huc6280_timer
    import huc6280_pkg::*;
#(
    parameter int unsigned PRESCALE = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reload_we_i,
    input  logic [6:0] reload_i,
    input  logic       ctl_we_i,
    input  logic       run_i,
    output logic [6:0] counter_o,
    output logic       run_o,
    output logic       underflow_o
);

    localparam int unsigned    PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [6:0]    reload_q, reload_d;
    logic          run_q, run_d;
    logic          wrap;

    assign wrap        = run_q && (presc_q == PS_LAST);
    assign underflow_o = wrap && (cnt_q == 7'd0);
    assign counter_o   = cnt_q;
    assign run_o       = run_q;

    // Next-state: prescaler/counter advance while running; a 0->1 run write restarts from reload
    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        run_d    = run_q;
        if (run_q) begin
            presc_d = wrap ? '0 : presc_q + PW'(1);
            if (wrap) begin
                cnt_d = (cnt_q == 7'd0) ? reload_q : cnt_q - 7'd1;
            end
        end
        if (reload_we_i) begin
            reload_d = reload_i;
        end
        if (ctl_we_i) begin
            run_d = run_i;
            if (run_i && !run_q) begin
                cnt_d   = reload_q;
                presc_d = '0;
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            reload_q <= '0;
            run_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/huc6280_timer_irq.sv
// huc6280_timer_irq: HuC6280 interval timer and interrupt controller as a
// memory-mapped responder on the 65C02 bus. Reads answer one cycle after the
// strobe; irq is a registered, masked OR of timer-pending and the external lines.
// Optional macro HUC6280_IRQ_SYNC_EN adds 2-flop synchronizers on irq1_n/irq2_n.
module huc6280_timer_irq
    import huc6280_pkg::*;
#(
    parameter int unsigned PRESCALE   = 1024,
    parameter logic [15:0] TIMER_BASE = TIMER_BASE_DEF,
    parameter logic [15:0] IRQC_BASE  = IRQC_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [7:0]  dIn,
    output logic [7:0]  dOut,
    output logic        hit,
    input  logic        irq1_n,
    input  logic        irq2_n,
    output logic        irq
);

    region_e     region;
    logic [1:0]  tmr_off;
    logic        wr_reload, wr_ctl, wr_mask, wr_ack;
    logic [6:0]  counter;
    logic        run;
    logic        underflow;
    logic        irq1_s, irq2_s;
    logic [2:0]  mask_q, mask_d;
    logic        tpend_q, tpend_d;
    logic        irq_q, irq_d;
    logic        hit_q, hit_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rd_data;
    logic [2:0]  src;
    logic        unused_bus_bits;

    assign unused_bus_bits = ^{addr[9:2], dIn[7]};

    assign region    = decode_region(addr, TIMER_BASE, IRQC_BASE);
    assign tmr_off   = {1'b0, addr[0]};
    assign wr_reload = we && (region == REG_TIMER) && (tmr_off == TMR_CNT);
    assign wr_ctl    = we && (region == REG_TIMER) && (tmr_off == TMR_CTL);
    assign wr_mask   = we && (region == REG_IRQC)  && (addr[1:0] == IRQ_MASK);
    assign wr_ack    = we && (region == REG_IRQC)  && (addr[1:0] == IRQ_STAT);

    huc6280_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .reload_we_i (wr_reload),
        .reload_i    (dIn[6:0]),
        .ctl_we_i    (wr_ctl),
        .run_i       (dIn[0]),
        .counter_o   (counter),
        .run_o       (run),
        .underflow_o (underflow)
    );

`ifdef HUC6280_IRQ_SYNC_EN
    logic [1:0] irq1_sync_q, irq2_sync_q;

    // Two-flop synchronizers for the asynchronous external IRQ lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq1_sync_q <= '1;
            irq2_sync_q <= '1;
        end else begin
            irq1_sync_q <= {irq1_sync_q[0], irq1_n};
            irq2_sync_q <= {irq2_sync_q[0], irq2_n};
        end
    end

    assign irq1_s = irq1_sync_q[1];
    assign irq2_s = irq2_sync_q[1];
`else
    assign irq1_s = irq1_n;
    assign irq2_s = irq2_n;
`endif

    // Register writes, pending flag, masked irq and the one-cycle read response
    always_comb begin
        mask_d  = mask_q;
        tpend_d = tpend_q;
        rd_data = '0;
        src     = '0;

        if (wr_mask) begin
            mask_d = dIn[2:0];
        end
        // Underflow is applied after the ack so a same-edge collision leaves tpend set
        if (wr_ack) begin
            tpend_d = 1'b0;
        end
        if (underflow) begin
            tpend_d = 1'b1;
        end

        src[TIMER_BIT] = tpend_q;
        src[IRQ1_BIT]  = ~irq1_s;
        src[IRQ2_BIT]  = ~irq2_s;
        irq_d          = |(src & ~mask_q);

        case (region)
            REG_TIMER: begin
                rd_data = (tmr_off == TMR_CTL) ? {7'b0, run} : {1'b0, counter};
            end
            REG_IRQC: begin
                case (addr[1:0])
                    IRQ_MASK: rd_data = {5'b0, mask_q};
                    IRQ_STAT: rd_data = {5'b0, src};
                    default:  rd_data = '0;
                endcase
            end
            default: rd_data = '0;
        endcase

        hit_d  = re && !we && (region != REG_NONE);
        dout_d = hit_d ? rd_data : '0;
    end

    // Controller state and bus response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            tpend_q <= 1'b0;
            irq_q   <= 1'b0;
            hit_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            mask_q  <= mask_d;
            tpend_q <= tpend_d;
            irq_q   <= irq_d;
            hit_q   <= hit_d;
            dout_q  <= dout_d;
        end
    end

    assign dOut = dout_q;
    assign hit  = hit_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_huc6280_timer_irq.sv
// tb_huc6280_timer_irq: scoreboard bench for huc6280_timer_irq with PRESCALE=4.
// Read expectations are queued at issue and compared when the response cycle arrives.
module tb_huc6280_timer_irq;

`ifdef HUC6280_IRQ_SYNC_EN
    localparam int unsigned EXT_LAT = 3;
`else
    localparam int unsigned EXT_LAT = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [7:0]  dIn;
    logic [7:0]  dOut;
    logic        hit;
    logic        irq1_n;
    logic        irq2_n;
    logic        irq;

    typedef struct {
        logic [15:0] a;
        logic        h;
        logic [7:0]  d;
    } rsp_t;

    rsp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic pend;

    huc6280_timer_irq #(
        .PRESCALE   (4),
        .TIMER_BASE (16'h0C00),
        .IRQC_BASE  (16'h1400)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .re      (re),
        .we      (we),
        .dIn     (dIn),
        .dOut    (dOut),
        .hit     (hit),
        .irq1_n  (irq1_n),
        .irq2_n  (irq2_n),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; dIn = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic h, input logic [7:0] d);
        rsp_t e;
        e.a = a; e.h = h; e.d = d;
        sb.push_back(e);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    // Bench-side record of which edges sampled a read strobe
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend <= 1'b0;
        else          pend <= re;
    end

    // Response checker: one entry per strobed cycle
    always @(negedge clk) begin
        if (pend) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk($sformatf("rd_hit@%h", e.a), {31'b0, hit}, {31'b0, e.h});
                chk($sformatf("rd_data@%h", e.a), {24'b0, dOut}, {24'b0, e.d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; dIn = '0;
        irq1_n = 1'b1; irq2_n = 1'b1;
        tick(2);
        chk("rst_hit",  {31'b0, hit}, 32'd0);
        chk("rst_dout", {24'b0, dOut}, 32'd0);
        chk("rst_irq",  {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        rd(16'h0C00, 1'b1, 8'h00);
        rd(16'h1402, 1'b1, 8'h00);
        rd(16'h1403, 1'b1, 8'h00);
        chk("post_rst_irq", {31'b0, irq}, 32'd0);

        // Underflow timing: run edge is edge 0, underflow edge 12
        wr(16'h0C00, 8'h02);
        wr(16'h0C01, 8'h01);
        rd(16'h0C00, 1'b1, 8'h02);
        tick(3);
        rd(16'h0C00, 1'b1, 8'h01);
        tick(3);
        rd(16'h0C00, 1'b1, 8'h00);
        tick(2);
        rd(16'h1403, 1'b1, 8'h00);
        chk("uf_irq_early", {31'b0, irq}, 32'd0);
        tick(1);
        chk("uf_irq", {31'b0, irq}, 32'd1);
        rd(16'h0C00, 1'b1, 8'h02);
        rd(16'h1403, 1'b1, 8'h04);

        // Mask and acknowledge
        wr(16'h1402, 8'h04);
        tick(1);
        chk("mask_irq", {31'b0, irq}, 32'd0);
        rd(16'h1403, 1'b1, 8'h04);
        wr(16'h1403, 8'h00);
        rd(16'h1403, 1'b1, 8'h00);
        wr(16'h1402, 8'h00);
        tick(1);
        chk("unmask_irq", {31'b0, irq}, 32'd0);

        // Ack lands on the underflow edge (edge 24)
        tick(1);
        wr(16'h1403, 8'h00);
        tick(1);
        chk("coll_irq", {31'b0, irq}, 32'd1);
        rd(16'h1403, 1'b1, 8'h04);
        wr(16'h1403, 8'h00);
        wr(16'h0C01, 8'h00);
        chk("ack_irq", {31'b0, irq}, 32'd0);

        // External IRQ1 then IRQ2
        irq1_n = 1'b0;
        tick(EXT_LAT - 1);
        chk("ext1_irq_early", {31'b0, irq}, 32'd0);
        tick(1);
        chk("ext1_irq", {31'b0, irq}, 32'd1);
        rd(16'h1403, 1'b1, 8'h02);
        wr(16'h1402, 8'h02);
        tick(1);
        chk("ext1_masked", {31'b0, irq}, 32'd0);
        irq1_n = 1'b1;
        irq2_n = 1'b0;
        wr(16'h1402, 8'h00);
        tick(EXT_LAT + 1);
        chk("ext2_irq", {31'b0, irq}, 32'd1);
        rd(16'h1403, 1'b1, 8'h01);
        irq2_n = 1'b1;
        tick(EXT_LAT + 1);
        chk("ext2_release", {31'b0, irq}, 32'd0);

        // Decode, mirrors and re/we collision
        wr(16'h0C01, 8'h01);
        rd(16'h0C05, 1'b1, 8'h01);
        wr(16'h0C01, 8'h00);
        rd(16'h0C05, 1'b1, 8'h00);
        rd(16'h2000, 1'b0, 8'h00);
        rd(16'h1400, 1'b1, 8'h00);
        rd(16'h1401, 1'b1, 8'h00);
        begin
            rsp_t e;
            e.a = 16'h0C00; e.h = 1'b0; e.d = 8'h00;
            sb.push_back(e);
            addr = 16'h0C00; dIn = 8'h7F; re = 1'b1; we = 1'b1;
            @(negedge clk);
            re = 1'b0; we = 1'b0;
        end
        wr(16'h0C01, 8'h01);
        rd(16'h0C00, 1'b1, 8'h7F);

        // Reset during a pending read response
        wr(16'h1402, 8'h07);
        addr = 16'h0C01; re = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        re = 1'b0;
        @(negedge clk);
        chk("midrst_hit",  {31'b0, hit}, 32'd0);
        chk("midrst_dout", {24'b0, dOut}, 32'd0);
        reset_n = 1'b1;
        rd(16'h0C01, 1'b1, 8'h00);
        rd(16'h1402, 1'b1, 8'h00);
        rd(16'h0C00, 1'b1, 8'h00);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/huc6280_timer_irq.md
Name: huc6280_timer_irq

Overview:
- Memory-mapped bus responder implementing the HuC6280 on-chip 7-bit interval timer and interrupt controller.
- Sits on the cpu_65c02 bus beside the memory model and answers the CPU's RE/WE cycles.
- Drives the CPU IRQ input from timer underflow and two external IRQ lines, all subject to a mask register.

Parameters:
- PRESCALE, 1024: clk cycles per timer decrement; must be ≥2.
- TIMER_BASE, 16'h0C00: base of the timer region, 1 KiB and mirrored.
- IRQC_BASE, 16'h1400: base of the interrupt-controller region, 1 KiB and mirrored.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- addr  in  16  CPU address bus (AB).
- re  in  1  CPU read strobe.
- we  in  1  CPU write strobe.
- dIn  in  8  write data (CPU DO).
- dOut  out  8  read data (to CPU DI mux).
- hit  out  1  dOut valid this cycle; bus mux selects dOut over memory.
- irq1_n  in  1  external IRQ1, active-low level.
- irq2_n  in  1  external IRQ2, active-low level.
- irq  out  1  to CPU IRQ, active-high level.

Behaviour:
- Reset values: dOut=8'h00, hit=0, irq=0, reload=7'h00, counter=7'h00, run=0, prescaler=0, mask=3'b000, tpend=0.
- Decode:
  - Timer region: addr[15:10]==TIMER_BASE[15:10]; addr[0] selects the register (0 = counter/reload, 1 = control).
  - IRQ region: addr[15:10]==IRQC_BASE[15:10]; addr[1:0] selects the register.
- Writes take effect on the clk edge where we=1:
  - Timer+0: reload<=dIn[6:0]; counter is not touched.
  - Timer+1: run<=dIn[0].
    - 0→1 transition: counter<=reload, prescaler<=0.
    - 1→1 transition: no effect.
  - IRQ+2: mask<=dIn[2:0]. Bit0=IRQ2, bit1=IRQ1, bit2=timer; 1 = disabled.
  - IRQ+3: any value clears tpend.
  - Other offsets: ignored.
- Reads: one-cycle latency. On the edge where re=1 and we=0 with a decoded address, the next cycle presents hit=1 and dOut:
  - Timer+0: {1'b0,counter}.
  - Timer+1: {7'b0,run}.
  - IRQ+2: {5'b0,mask}.
  - IRQ+3: {5'b0,tpend,~irq1_n,~irq2_n}.
  - IRQ+0/+1: 8'h00.
  - Otherwise, next cycle: hit=0, dOut=8'h00.
- re and we asserted together: the write is performed and the read is ignored (hit=0).
- Timer while run=1:
  - prescaler counts 0..PRESCALE-1 and wraps.
  - On wrap with counter≠0: counter decrements.
  - On wrap with counter==0: counter<=reload and tpend<=1.
  - reload=0 gives an underflow every PRESCALE cycles.
- run=0: prescaler and counter hold.
- Write to reload while running: used at the next underflow only.
- Simultaneous IRQ+3 write and underflow: set wins, tpend=1.
- irq: registered; irq <= |({tpend,~irq1_n,~irq2_n} & ~mask). It lags its cause by one cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any pending read response is dropped.

Optional Feature:
- Macro HUC6280_IRQ_SYNC_EN.
- Defined: irq1_n and irq2_n pass through a 2-flop synchronizer (reset to 1) before status/irq use. Input-to-irq latency is 3 cycles.
- Undefined: inputs are used directly. Latency is 1 cycle.

Decomposition:
- Package huc6280_pkg holds:
  - Register offset localparams: TMR_CNT=0, TMR_CTL=1, IRQ_MASK=2, IRQ_STAT=3.
  - Mask bit indices: IRQ2_BIT=0, IRQ1_BIT=1, TIMER_BIT=2.
  - Default bases.
- Sub-module huc6280_timer owns prescaler/counter/reload/run and emits a one-cycle underflow pulse.
- The top level handles decode, read mux, mask, pending and irq.

Test Plan (PRESCALE=4):
- Reset: hold reset_n=0 for 2 cycles, then read 0C00, 1402 and 1403 → each returns 8'h00 with hit=1 one cycle after re; irq=0.
- Underflow timing: write 0C00=8'h02, then 0C01=8'h01 → counter reads 2,1,0 at 4-cycle steps; underflow after 12 cycles; tpend=1, irq=1 one cycle later; counter reloads to 2.
- Mask and ack: with tpend=1, write 1402=8'h04 → irq=0 next cycle while 1403 still reads 8'h04. Write 1403=8'h00 → 1403 reads 8'h00. Write 1402=8'h00 → irq stays 0.
- Ack/underflow collision: write 1403 on the exact underflow edge → tpend=1 and irq remains 1.
- External IRQ: irq1_n=0 with mask=0 → irq=1 after 1 cycle (3 cycles with HUC6280_IRQ_SYNC_EN); 1403 reads 8'h02. Write mask=8'h02 → irq=0.
- Decode and collision:
  - Read 0C05 (mirror, addr[0]=1) → returns run.
  - Read 2000 → hit=0, dOut=8'h00.
  - re and we together on 0C00 with dIn=8'h7F → reload=7F, hit=0.
